// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates one active-low column drive, samples the rows,
// classifies each full scan frame as NONE/SINGLE/MULTI and debounces whole frames.
module keypad_scanner #(
   parameter int SETTLE_CYCLES   = 1000,
   parameter int DEBOUNCE_FRAMES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down,
   output logic       multi_key
);

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_SINGLE = 2'd1,
      RES_MULTI  = 2'd2
   } res_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } state_e;

   localparam logic [15:0] DWELL_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  STABLE_MAX = 8'(DEBOUNCE_FRAMES);

   logic [3:0]  sync1_q, sync1_d;
   logic [3:0]  sync2_q, sync2_d;
   logic [15:0] dwell_q, dwell_d;
   logic [1:0]  col_idx_q, col_idx_d;
   logic [3:0]  col_n_q, col_n_d;
   res_e        acc_kind_q, acc_kind_d;
   logic [3:0]  acc_code_q, acc_code_d;
   res_e        prev_kind_q, prev_kind_d;
   logic [3:0]  prev_code_q, prev_code_d;
   logic [7:0]  stable_q, stable_d;
   state_e      state_q, state_d;
   logic [3:0]  key_code_q, key_code_d;
   logic        key_valid_q, key_valid_d;
   logic        key_down_q, key_down_d;
   logic        multi_q, multi_d;

   logic [3:0]  row_low;
   logic [2:0]  low_cnt;
   logic [1:0]  row_idx;
   res_e        samp_kind;
   res_e        merged_kind;
   logic [3:0]  merged_code;
   logic        sample;
   logic        same_result;

   // Row decode of the synchronized sample for the currently driven column.
   always_comb begin
      row_low = ~sync2_q;
      low_cnt = {2'b00, row_low[0]} + {2'b00, row_low[1]}
              + {2'b00, row_low[2]} + {2'b00, row_low[3]};
      row_idx = 2'd0;
      case (row_low)
         4'b0010: row_idx = 2'd1;
         4'b0100: row_idx = 2'd2;
         4'b1000: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
      if (low_cnt == 3'd0) begin
         samp_kind = RES_NONE;
      end else if (low_cnt == 3'd1) begin
         samp_kind = RES_SINGLE;
      end else begin
         samp_kind = RES_MULTI;
      end
   end

   // Fold this column's sample into the frame accumulated so far.
   always_comb begin
      merged_kind = acc_kind_q;
      merged_code = acc_code_q;
      case (acc_kind_q)
         RES_NONE: begin
            merged_kind = samp_kind;
            merged_code = (samp_kind == RES_SINGLE) ? {col_idx_q, row_idx} : 4'd0;
         end
         RES_SINGLE: begin
            merged_kind = (samp_kind == RES_NONE) ? RES_SINGLE : RES_MULTI;
            merged_code = (samp_kind == RES_NONE) ? acc_code_q : 4'd0;
         end
         default: begin
            merged_kind = RES_MULTI;
            merged_code = 4'd0;
         end
      endcase
      same_result = (merged_kind == prev_kind_q)
                 && ((merged_kind != RES_SINGLE) || (merged_code == prev_code_q));
   end

   always_comb begin
      sync1_d     = row_n;
      sync2_d     = sync1_q;
      dwell_d     = dwell_q;
      col_idx_d   = col_idx_q;
      col_n_d     = col_n_q;
      acc_kind_d  = acc_kind_q;
      acc_code_d  = acc_code_q;
      prev_kind_d = prev_kind_q;
      prev_code_d = prev_code_q;
      stable_d    = stable_q;
      state_d     = state_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      multi_d     = multi_q;
      sample      = (dwell_q == DWELL_LAST);

      if (!sample) begin
         dwell_d = dwell_q + 16'd1;
      end else begin
         dwell_d   = 16'd0;
         col_idx_d = col_idx_q + 2'd1;
         col_n_d   = {col_n_q[2:0], col_n_q[3]};
         if (col_idx_q != 2'd3) begin
            acc_kind_d = merged_kind;
            acc_code_d = merged_code;
         end else begin
            // Frame evaluation: debounce on whole-frame results, not individual rows.
            acc_kind_d  = RES_NONE;
            acc_code_d  = 4'd0;
            prev_kind_d = merged_kind;
            prev_code_d = merged_code;
            if (!same_result) begin
               stable_d = 8'd1;
            end else if (stable_q >= STABLE_MAX) begin
               stable_d = STABLE_MAX;
            end else begin
               stable_d = stable_q + 8'd1;
            end
            multi_d = (merged_kind == RES_MULTI);
            if (stable_d == STABLE_MAX) begin
               if (state_q == ST_IDLE && merged_kind == RES_SINGLE) begin
                  state_d     = ST_HELD;
                  key_code_d  = merged_code;
                  key_down_d  = 1'b1;
                  key_valid_d = 1'b1;
               end else if (state_q == ST_HELD && merged_kind == RES_NONE) begin
                  state_d    = ST_IDLE;
                  key_down_d = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 4'b1111;
         sync2_q     <= 4'b1111;
         dwell_q     <= 16'd0;
         col_idx_q   <= 2'd0;
         col_n_q     <= 4'b1110;
         acc_kind_q  <= RES_NONE;
         acc_code_q  <= 4'd0;
         prev_kind_q <= RES_NONE;
         prev_code_q <= 4'd0;
         stable_q    <= 8'd0;
         state_q     <= ST_IDLE;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         multi_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         dwell_q     <= dwell_d;
         col_idx_q   <= col_idx_d;
         col_n_q     <= col_n_d;
         acc_kind_q  <= acc_kind_d;
         acc_code_q  <= acc_code_d;
         prev_kind_q <= prev_kind_d;
         prev_code_q <= prev_code_d;
         stable_q    <= stable_d;
         state_q     <= state_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
         multi_q     <= multi_d;
      end
   end

   assign col_n     = col_n_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;
   assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       multi_key;

   logic       press_en;
   logic [1:0] press_col;
   logic [3:0] press_rows;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulses = 0;

   keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_FRAMES(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .multi_key (multi_key)
   );

   always #5 clk = ~clk;

   // Physical keypad: pressed rows pull low only while their column is driven.
   assign row_n = (press_en && (col_n[press_col] == 1'b0)) ? ~press_rows : 4'hF;

   always @(negedge clk) begin
      if (!rst && key_valid) pulses <= pulses + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      rst = 1'b1; press_en = 1'b0; press_col = 2'd0; press_rows = 4'd0;
      step(); step();
      rst = 1'b0;
      cyc = 0;
      chk("rst_col", int'(col_n), 'hE);
      chk("rst_code", int'(key_code), 0);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_down", int'(key_down), 0);
      chk("rst_multi", int'(multi_key), 0);
      run_to(4);  chk("col1", int'(col_n), 'hD);
      run_to(8);  chk("col2", int'(col_n), 'hB);
      run_to(12); chk("col3", int'(col_n), 'h7);
      run_to(16); chk("col0_wrap", int'(col_n), 'hE);

      // Clean press: column 2, row 1 -> code 9
      press_en = 1'b1; press_col = 2'd2; press_rows = 4'b0010;
      run_to(63); chk("press_pre_valid", int'(key_valid), 0);
                  chk("press_pre_down", int'(key_down), 0);
      run_to(64); chk("press_valid", int'(key_valid), 1);
                  chk("press_down", int'(key_down), 1);
                  chk("press_code", int'(key_code), 9);
      run_to(65); chk("press_pulse_width", int'(key_valid), 0);
      run_to(112); chk("held_pulses", pulses, 1);
                   chk("held_down", int'(key_down), 1);

      // Release for three frames
      press_en = 1'b0;
      run_to(159); chk("rel_pre_down", int'(key_down), 1);
      run_to(160); chk("rel_down", int'(key_down), 0);
                   chk("rel_code_kept", int'(key_code), 9);

      // Bounce: key present in alternate frames for 10 frames
      for (int i = 0; i < 10; i++) begin
         press_en = (i % 2 == 0);
         run_to(176 + 16 * i);
         chk("bounce_down", int'(key_down), 0);
      end
      chk("bounce_pulses", pulses, 1);
      press_en = 1'b1;
      run_to(367); chk("bounce_hold_pre", int'(key_valid), 0);
      run_to(368); chk("bounce_hold_valid", int'(key_valid), 1);
                   chk("bounce_hold_code", int'(key_code), 9);
      run_to(370); chk("bounce_hold_pulses", pulses, 2);

      // Release, then re-press column 3 row 0 -> code 12
      press_en = 1'b0;
      run_to(416); chk("rel2_down", int'(key_down), 0);
      press_en = 1'b1; press_col = 2'd3; press_rows = 4'b0001;
      run_to(463); chk("repress_pre_down", int'(key_down), 0);
      run_to(464); chk("repress_valid", int'(key_valid), 1);
                   chk("repress_code", int'(key_code), 12);
                   chk("repress_down", int'(key_down), 1);
      press_en = 1'b0;
      run_to(512); chk("rel3_down", int'(key_down), 0);

      // Multi-key: rows 0 and 2 in column 1 for five frames
      press_en = 1'b1; press_col = 2'd1; press_rows = 4'b0101;
      run_to(527); chk("multi_pre", int'(multi_key), 0);
      run_to(528); chk("multi_on", int'(multi_key), 1);
      run_to(592); chk("multi_still", int'(multi_key), 1);
                   chk("multi_down", int'(key_down), 0);
                   chk("multi_pulses", pulses, 3);
      press_en = 1'b0;
      run_to(607); chk("multi_rel_pre", int'(multi_key), 1);
      run_to(608); chk("multi_off", int'(multi_key), 0);
                   chk("multi_code_kept", int'(key_code), 12);

      // Reset while HELD, mid-frame, with the key still pressed
      press_en = 1'b1; press_col = 2'd2; press_rows = 4'b0010;
      run_to(656); chk("pre_rst_valid", int'(key_valid), 1);
                   chk("pre_rst_down", int'(key_down), 1);
      run_to(662);
      rst = 1'b1;
      run_to(663); chk("midrst_down", int'(key_down), 0);
                   chk("midrst_col", int'(col_n), 'hE);
                   chk("midrst_code", int'(key_code), 0);
      rst = 1'b0;
      run_to(710); chk("post_rst_pre_valid", int'(key_valid), 0);
                   chk("post_rst_pre_down", int'(key_down), 0);
      run_to(711); chk("post_rst_valid", int'(key_valid), 1);
                   chk("post_rst_down", int'(key_down), 1);
                   chk("post_rst_code", int'(key_code), 9);
      run_to(740); chk("final_pulses", pulses, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
